// File: rtl/if_pc_sequencer.sv
`default_nettype none
//==============================================================================
// Module   : if_pc_sequencer
// Purpose  : Fetch-stage PC owner; single-outstanding imem req/ready/valid
//            sequencer with redirect, stall hold and in-flight kill.
//            Optional build macro: MISALIGN_TRAP_EN (misaligned target traps).
// Revision : 1.0 - initial release
//==============================================================================
module if_pc_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic        imem_valid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] if_inst_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_pc4_o,
    output logic        flush_o
`ifdef MISALIGN_TRAP_EN
    ,
    output logic        misalign_o
`endif
);

`ifdef MISALIGN_TRAP_EN
    localparam bit c_TRAP_EN = 1'b1;
`else
    localparam bit c_TRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_RST  = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_kill;

    logic        w_redirect;
    logic        w_accept;
    logic        w_misaligned;
    logic [31:0] w_sel;
    logic [31:0] w_target;

    // Jump has priority over a simultaneous taken branch.
    assign w_redirect   = jump_i | branch_taken_i;
    assign w_sel        = jump_i ? jump_target_i : branch_target_i;
    assign w_misaligned = c_TRAP_EN && (w_sel[1:0] != 2'b00);
    assign w_target     = w_misaligned ? TRAP_VECTOR : {w_sel[31:2], 2'b00};
    assign w_accept     = w_redirect && (r_state != S_RST);

    assign imem_req_o   = (r_state == S_REQ);
    assign imem_addr_o  = r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_RST;
            r_pc       <= RESET_PC;
            r_kill     <= 1'b0;
            if_valid_o <= 1'b0;
            if_inst_o  <= 32'h0;
            if_pc_o    <= 32'h0;
            if_pc4_o   <= 32'h0;
            flush_o    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misalign_o <= 1'b0;
`endif
        end else begin
            flush_o <= w_accept;
`ifdef MISALIGN_TRAP_EN
            misalign_o <= w_accept && w_misaligned;
`endif
            case (r_state)
                S_RST: r_state <= S_REQ;

                S_REQ: begin
                    if (w_redirect) begin
                        r_pc <= w_target;
                        // Old address already accepted: its response must be discarded.
                        if (imem_ready_i) begin
                            r_kill  <= 1'b1;
                            r_state <= S_WAIT;
                        end
                    end else if (imem_ready_i) begin
                        r_state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (!imem_valid_i) begin
                        if (w_redirect) begin
                            r_pc   <= w_target;
                            r_kill <= 1'b1;
                        end
                    end else if (r_kill || w_redirect) begin
                        r_kill  <= 1'b0;
                        if (w_redirect) begin
                            r_pc <= w_target;
                        end
                        r_state <= S_REQ;
                    end else begin
                        if_inst_o  <= imem_rdata_i;
                        if_pc_o    <= r_pc;
                        if_pc4_o   <= r_pc + 32'd4;
                        if_valid_o <= 1'b1;
                        r_pc       <= r_pc + 32'd4;
                        r_state    <= S_OUT;
                    end
                end

                S_OUT: begin
                    if (w_redirect) begin
                        if_valid_o <= 1'b0;
                        r_pc       <= w_target;
                        r_state    <= S_REQ;
                    end else if (!stall_i) begin
                        if_valid_o <= 1'b0;
                        r_state    <= S_REQ;
                    end
                end

                default: r_state <= S_RST;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_pc_sequencer.sv
`default_nettype none
//==============================================================================
// Module   : tb_if_pc_sequencer
// Purpose  : Self-checking bench for if_pc_sequencer (honours MISALIGN_TRAP_EN).
// Revision : 1.0 - initial release
//==============================================================================
module tb_if_pc_sequencer;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] c_TRAP_PC  = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        branch_taken_i = 1'b0;
    logic [31:0] branch_target_i = 32'h0;
    logic        jump_i = 1'b0;
    logic [31:0] jump_target_i = 32'h0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i = 1'b1;
    logic        imem_valid_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic        if_valid_o;
    logic [31:0] if_inst_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_pc4_o;
    logic        flush_o;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_o;
`endif

    if_pc_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall_i),
        .branch_taken_i (branch_taken_i),
        .branch_target_i(branch_target_i),
        .jump_i         (jump_i),
        .jump_target_i  (jump_target_i),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_ready_i   (imem_ready_i),
        .imem_valid_i   (imem_valid_i),
        .imem_rdata_i   (imem_rdata_i),
        .if_valid_o     (if_valid_o),
        .if_inst_o      (if_inst_o),
        .if_pc_o        (if_pc_o),
        .if_pc4_o       (if_pc4_o),
        .flush_o        (flush_o)
`ifdef MISALIGN_TRAP_EN
        ,
        .misalign_o     (misalign_o)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } out_t;
    out_t expOut[$];

    typedef struct {
        logic        jmp;
        logic [31:0] jTgt;
        logic        br;
        logic [31:0] bTgt;
        logic [31:0] expPc;
        logic        expMis;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory words are tagged with the inverted address.
    task automatic expectFetch(input logic [31:0] a);
        out_t e;
        e.pc   = a;
        e.inst = ~a;
        expOut.push_back(e);
    endtask

    function automatic logic [31:0] expTarget(input logic [31:0] t);
        if (t[1:0] == 2'b00) return t;
`ifdef MISALIGN_TRAP_EN
        return c_TRAP_PC;
`else
        return {t[31:2], 2'b00};
`endif
    endfunction

    task automatic waitValid(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!if_valid_o && n < 20);
        if (!if_valid_o) begin
            checks++;
            errors++;
            $display("FAIL %s: if_valid_o never rose within %0d cycles", name, n);
        end
    endtask

    // Memory model: accepts on req&ready, answers with a one-cycle valid memLat cycles later.
    int          memLat = 1;
    int          pendCnt = 0;
    logic [31:0] pendAddr = 32'h0;
    always @(negedge clk) begin
        #1;
        imem_valid_i = 1'b0;
        if (pendCnt > 0) begin
            pendCnt--;
            if (pendCnt == 0) begin
                imem_valid_i = 1'b1;
                imem_rdata_i = ~pendAddr;
            end
        end
        if (imem_req_o && imem_ready_i) begin
            pendCnt  = memLat;
            pendAddr = imem_addr_o;
        end
    end

    // Scoreboard: each new IF output is popped and compared.
    logic monPrev = 1'b0;
    always @(negedge clk) begin
        out_t e;
        if (if_valid_o && !monPrev) begin
            if (expOut.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_fetch: got pc 0x%08h with no expected fetch", if_pc_o);
            end else begin
                e = expOut.pop_front();
                chk("if_pc", if_pc_o, e.pc);
                chk("if_inst", if_inst_o, e.inst);
                chk("if_pc4", if_pc4_o, e.pc + 32'd4);
            end
        end
        monPrev = if_valid_o;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int n;
        int flushCnt;
        logic sawV;
        logic [31:0] last;

        vecs[0] = '{1'b1, 32'h0000_0200, 1'b1, 32'h0000_0300, 32'h0, 1'b0};
        vecs[1] = '{1'b0, 32'h0000_0000, 1'b1, 32'h0000_0102, 32'h0, 1'b0};
        vecs[2] = '{1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0000_0000, 32'h0, 1'b0};
        vecs[3] = '{1'b0, 32'h0000_0000, 1'b1, 32'h0000_0044, 32'h0, 1'b0};
        vecs[4] = '{1'b1, 32'h0000_1003, 1'b1, 32'h0000_0500, 32'h0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            last           = vecs[i].jmp ? vecs[i].jTgt : vecs[i].bTgt;
            vecs[i].expPc  = expTarget(last);
            vecs[i].expMis = (last[1:0] != 2'b00);
        end

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req", {31'h0, imem_req_o}, 32'h0);
        chk("rst_addr", imem_addr_o, c_RESET_PC);
        chk("rst_valid", {31'h0, if_valid_o}, 32'h0);
        chk("rst_flush", {31'h0, flush_o}, 32'h0);
        chk("rst_ifpc", if_pc_o, 32'h0);
        expectFetch(32'h0);
        expectFetch(32'h4);
        expectFetch(32'h8);
        rst = 1'b0;

        // Sequential fetch, one instruction every three cycles
        waitValid("first_fetch");
        cnt = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (if_valid_o) cnt++;
        end
        chk("throughput", cnt, 2);
        chk("at_pc8_valid", {31'h0, if_valid_o}, 32'h1);

        // Stall hold at pc 0x8
        stall_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("stall_valid", {31'h0, if_valid_o}, 32'h1);
            chk("stall_pc", if_pc_o, 32'h8);
            chk("stall_inst", if_inst_o, ~32'h8);
            chk("stall_req", {31'h0, imem_req_o}, 32'h0);
            if (i == 4) begin
                stall_i = 1'b0;
                memLat  = 4;
            end
        end
        @(negedge clk);
        chk("post_stall_req", {31'h0, imem_req_o}, 32'h1);
        chk("post_stall_addr", imem_addr_o, 32'hC);

        // Branch while waiting on a late response
        @(negedge clk);
        branch_taken_i  = 1'b1;
        branch_target_i = 32'h0000_0100;
        @(negedge clk);
        branch_taken_i = 1'b0;
        chk("late_flush", {31'h0, flush_o}, 32'h1);
        chk("late_wait_req", {31'h0, imem_req_o}, 32'h0);
        memLat = 1;
        expectFetch(32'h100);
        n = 0;
        sawV = 1'b0;
        flushCnt = 0;
        do begin
            @(negedge clk);
            n++;
            if (if_valid_o) sawV = 1'b1;
            if (flush_o) flushCnt++;
        end while (!imem_req_o && n < 10);
        chk("late_no_valid", {31'h0, sawV}, 32'h0);
        chk("late_flush_once", flushCnt, 0);
        chk("late_req", {31'h0, imem_req_o}, 32'h1);
        chk("late_addr", imem_addr_o, 32'h100);

        // Redirect table, each applied in S_OUT
        for (int i = 0; i < 5; i++) begin
            waitValid("vec_wait");
            jump_i          = vecs[i].jmp;
            jump_target_i   = vecs[i].jTgt;
            branch_taken_i  = vecs[i].br;
            branch_target_i = vecs[i].bTgt;
            @(negedge clk);
            jump_i         = 1'b0;
            branch_taken_i = 1'b0;
            chk("vec_flush", {31'h0, flush_o}, 32'h1);
            chk("vec_valid_drop", {31'h0, if_valid_o}, 32'h0);
            chk("vec_req", {31'h0, imem_req_o}, 32'h1);
            chk("vec_addr", imem_addr_o, vecs[i].expPc);
`ifdef MISALIGN_TRAP_EN
            chk("vec_misalign", {31'h0, misalign_o}, {31'h0, vecs[i].expMis});
`endif
            expectFetch(vecs[i].expPc);
            expectFetch(vecs[i].expPc + 32'd4);
            waitValid("vec_target");
            @(negedge clk);
            chk("vec_next_addr", imem_addr_o, vecs[i].expPc + 32'd4);
            chk("vec_flush_clear", {31'h0, flush_o}, 32'h0);
        end

        // Redirect in S_REQ after the old address was accepted: response killed
        waitValid("kill_wait");
        @(negedge clk);
        chk("kill_req", {31'h0, imem_req_o}, 32'h1);
        jump_i        = 1'b1;
        jump_target_i = 32'h0000_0400;
        @(negedge clk);
        jump_i = 1'b0;
        chk("kill_flush", {31'h0, flush_o}, 32'h1);
        chk("kill_wait_req", {31'h0, imem_req_o}, 32'h0);
        @(negedge clk);
        chk("kill_req2", {31'h0, imem_req_o}, 32'h1);
        chk("kill_addr", imem_addr_o, 32'h400);
        chk("kill_valid", {31'h0, if_valid_o}, 32'h0);
        memLat = 3;

        // Reset mid-fetch; the stale response must be ignored
        @(negedge clk);
        chk("rst_mid_wait", {31'h0, imem_req_o}, 32'h0);
        rst = 1'b1;
        expectFetch(c_RESET_PC);
        @(negedge clk);
        rst = 1'b0;
        memLat = 1;
        chk("rst_mid_req", {31'h0, imem_req_o}, 32'h0);
        chk("rst_mid_addr", imem_addr_o, c_RESET_PC);
        chk("rst_mid_valid", {31'h0, if_valid_o}, 32'h0);
        waitValid("rst_refetch");
        repeat (2) @(negedge clk);
        chk("scoreboard_empty", expOut.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
